// File: rtl/rx_byte_buffer_if.sv
// Byte stream handshake between decoder (writer), buffer and UART transmitter (reader).
interface rx_byte_buffer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output wr_data, wr_valid, rd_ready,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/rx_byte_buffer.sv
// Receive-side byte FIFO with first-word fall-through read and sticky, saturating overflow count.
module rx_byte_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   en,
    rx_byte_buffer_if.slave        bus,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic [CNT_W-1:0]       ovf_cnt,
    input  logic                   clr_ovf
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic              push;
    logic              pop;
    logic              drop;

    // Flags derive from the level register only, so nothing reaches them from wr_valid.
    assign full         = (level == LVL_W'(DEPTH));
    assign empty        = (level == '0);
    assign bus.rd_valid = ~empty;
    assign bus.rd_data  = mem[rp];

    assign pop  = en & bus.rd_valid & bus.rd_ready;
    assign push = en & bus.wr_valid & (~full | pop);
    assign drop = en & bus.wr_valid & full & ~pop;

    // Storage and write pointer.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wp <= '0;
        end else if (push) begin
            mem[wp] <= bus.wr_data;
            wp      <= wp + PTR_W'(1);
        end
    end

    // Read pointer and occupancy.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rp    <= '0;
            level <= '0;
        end else begin
            if (pop) rp <= rp + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Overflow tracking; a drop coinciding with a clear leaves exactly one count.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (en) begin
            if (clr_ovf) begin
                ovf     <= drop;
                ovf_cnt <= drop ? CNT_W'(1) : '0;
            end else if (drop) begin
                ovf <= 1'b1;
                if (ovf_cnt != CNT_MAX) ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rx_byte_buffer.sv
// Directed bench for rx_byte_buffer: stimulus queues expected bytes, a monitor checks every pop.
module tb_rx_byte_buffer;
    logic       clk = 1'b0;
    logic       arstn;
    logic       en;
    logic       clr_ovf;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       ovf;
    logic [7:0] ovf_cnt;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    rx_byte_buffer_if #(.DATA_W(8)) bus ();

    rx_byte_buffer #(.DATA_W(8), .DEPTH(16), .CNT_W(8)) dut (
        .clk     (clk),
        .arstn   (arstn),
        .en      (en),
        .bus     (bus),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .ovf     (ovf),
        .ovf_cnt (ovf_cnt),
        .clr_ovf (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop must deliver the oldest outstanding expected byte.
    always @(negedge clk) begin
        if (arstn && en && bus.rd_valid && bus.rd_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data", bus.rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.rd_data !== e) begin
                    miscompares++;
                    $display("FAIL pop_data: got 0x%0h, expected 0x%0h at %0t", bus.rd_data, e, $time);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic rdy);
        bus.wr_valid = v;
        bus.wr_data  = d;
        bus.rd_ready = rdy;
        cyc();
        bus.wr_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.rd_ready = 1'b1;
        repeat (n) cyc();
        bus.rd_ready = 1'b0;
    endtask

    initial begin
        int max_lvl;
        arstn = 1'b0; en = 1'b1; clr_ovf = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
        repeat (3) cyc();
        check("rst_level", 32'(level), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 0);
        arstn = 1'b1;
        cyc();

        // Single byte, one-cycle latency.
        exp_q.push_back(8'hA5);
        drive(1'b1, 8'hA5, 1'b0);
        check("one_rd_valid", 32'(bus.rd_valid), 1);
        check("one_rd_data", 32'(bus.rd_data), 32'h A5);
        check("one_level", 32'(level), 1);
        drain(1);
        check("one_empty", 32'(empty), 1);
        check("one_level0", 32'(level), 0);

        // Fill, overflow two bytes, then push-with-pop while full.
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            drive(1'b1, 8'(i), 1'b0);
        end
        check("fill_full", 32'(full), 1);
        check("fill_level", 32'(level), 16);
        drive(1'b1, 8'h10, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        check("drop_ovf", 32'(ovf), 1);
        check("drop_cnt", 32'(ovf_cnt), 2);
        check("drop_level", 32'(level), 16);
        exp_q.push_back(8'h55);
        drive(1'b1, 8'h55, 1'b1);
        check("wt_level", 32'(level), 16);
        check("wt_cnt", 32'(ovf_cnt), 2);
        drain(16);
        check("drain_empty", 32'(empty), 1);
        check("drain_q", 32'(exp_q.size()), 0);
        clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
        check("clr1_ovf", 32'(ovf), 0);
        check("clr1_cnt", 32'(ovf_cnt), 0);

        // Sustained push and pop; pointers wrap past 15.
        max_lvl = 0;
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(8'(i * 37 + 11));
            drive(1'b1, 8'(i * 37 + 11), 1'b1);
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        drain(1);
        check("stream_max_level", 32'(max_lvl), 1);
        check("stream_empty", 32'(empty), 1);
        check("stream_q", 32'(exp_q.size()), 0);

        // Saturation and clear-with-drop.
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'hC0 + i));
            drive(1'b1, 8'(8'hC0 + i), 1'b0);
        end
        bus.wr_valid = 1'b1;
        repeat (300) cyc();
        check("sat_cnt", 32'(ovf_cnt), 255);
        check("sat_ovf", 32'(ovf), 1);
        clr_ovf = 1'b1; cyc();
        check("clrdrop_cnt", 32'(ovf_cnt), 1);
        check("clrdrop_ovf", 32'(ovf), 1);
        bus.wr_valid = 1'b0; cyc(); clr_ovf = 1'b0;
        check("clr2_cnt", 32'(ovf_cnt), 0);
        check("clr2_ovf", 32'(ovf), 0);
        drain(16);
        check("sat_drain_empty", 32'(empty), 1);

        // Asynchronous reset mid-cycle discards contents.
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'(8'h30 + i));
            drive(1'b1, 8'(8'h30 + i), 1'b0);
        end
        check("pre_rst_level", 32'(level), 5);
        #2 arstn = 1'b0;
        exp_q.delete();
        #1;
        check("arst_level", 32'(level), 0);
        check("arst_empty", 32'(empty), 1);
        check("arst_rd_valid", 32'(bus.rd_valid), 0);
        check("arst_rd_data", 32'(bus.rd_data), 0);
        cyc();
        arstn = 1'b1;
        cyc();

        // Enable low: writes ignored, no drops counted.
        en = 1'b0;
        drive(1'b1, 8'h99, 1'b1);
        check("en0_level_empty", 32'(level), 0);
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h60 + i));
            drive(1'b1, 8'(8'h60 + i), 1'b0);
        end
        en = 1'b0;
        drive(1'b1, 8'h77, 1'b1);
        check("en0_level_full", 32'(level), 16);
        check("en0_cnt", 32'(ovf_cnt), 0);
        check("en0_ovf", 32'(ovf), 0);
        en = 1'b1;
        drain(16);
        check("final_empty", 32'(empty), 1);
        check("final_q", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rx_byte_buffer.md
# rx_byte_buffer

Receive-side byte FIFO between the Hamming decoder and the UART transmitter in `transceiver_top`. It captures each corrected byte presented by the decoder on its one-cycle `data_valid` strobe and holds it until the UART transmitter is ready to serialise it onto `q`. Decoder bursts are absorbed without loss up to `DEPTH` bytes. Bytes that arrive while the buffer is full are counted and flagged, never written.

## Interface
- `DATA_W`, 8: byte width, matching `decoder_out`.
- `DEPTH`, 16: number of entries. Must be a power of two and at least 2.
- `CNT_W`, 8: width of the overflow counter.

- `clk`  in  1  system clock, rising edge.
- `arstn`  in  1  reset, asynchronous, active-low.
- `en`  in  1  synchronous enable. When low, the block does not push or pop, and all state is held.
- `wr_data`  in  DATA_W  byte from the decoder.
- `wr_valid`  in  1  one-cycle strobe from the decoder's `data_valid`.
- `rd_data`  out  DATA_W  head-of-queue byte, first-word fall-through.
- `rd_valid`  out  1  high whenever the FIFO is not empty.
- `rd_ready`  in  1  UART transmitter accepts `rd_data` this cycle.
- `full`  out  1  level equals DEPTH.
- `empty`  out  1  level equals 0.
- `level`  out  $clog2(DEPTH)+1  current occupancy, from 0 to DEPTH.
- `ovf`  out  1  sticky flag, set when a byte is dropped.
- `ovf_cnt`  out  CNT_W  count of dropped bytes, saturating.
- `clr_ovf`  in  1  synchronous clear of `ovf` and `ovf_cnt`.

## Operation
- Storage is a register array `mem[DEPTH]` with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits. Both pointers wrap naturally from DEPTH-1 to 0.
- `level` is a separate registered counter. It is the single source for `full` and `empty`.
- pop = `en & rd_valid & rd_ready`.
- push = `en & wr_valid & (!full | pop)`.
- A push writes `mem[wp] <= wr_data` and increments `wp`.
- A pop increments `rp`.
- Level update per cycle:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Full with simultaneous push and pop: the write is accepted (write-through on pop) and `level` stays DEPTH.
- Empty with `wr_valid`: the write is accepted. No pop is possible because `rd_valid` is 0.
- `rd_data = mem[rp]`, driven combinationally from registered state. When empty, `rd_data` shows stale storage and must be ignored.
- Drop condition = `en & wr_valid & full & !pop`. On a drop:
  - `ovf` is set to 1.
  - `ovf_cnt` increments, saturating at 2^CNT_W−1.
- `wr_valid` while `en` is low is ignored and is not counted as a drop.
- `clr_ovf` (honoured only when `en` is high):
  - Clears `ovf` to 0 and `ovf_cnt` to 0.
  - If a drop occurs in the same cycle, the result is `ovf` = 1 and `ovf_cnt` = 1.
- The handshake is valid/ready. The consumer may hold `rd_ready` high continuously. `rd_data` changes only after a pop or after a push into an empty FIFO.
- There is no FSM. Behaviour is fully determined by the pointer and level counters.

## Timing
- Reset values (`arstn` low, asynchronous):
  - `wp`, `rp`, `level` = 0.
  - `empty` = 1, `full` = 0, `rd_valid` = 0.
  - `ovf` = 0, `ovf_cnt` = 0.
  - `mem` cleared to 0, so `rd_data` = 0.
- Reset release: the block is active on the first rising edge at which `arstn` is high.
- Write-to-read latency: a push at edge N into an empty FIFO makes `rd_valid` = 1 and `rd_data` = the pushed byte after edge N, i.e. 1 cycle.
- Pop: with `rd_valid` and `rd_ready` high at edge N, the next entry (or `empty`) appears after edge N.
- Throughput: one push and one pop per cycle, sustained.
- Reset asserted mid-operation: all contents are discarded immediately. No partial pop is visible after reset.
- `full`, `empty`, `level`, `ovf`, `ovf_cnt` are all registered. No output has a combinational path from `wr_valid`.
- `rd_valid` depends only on registered state.
- `rd_data` depends combinationally on `rp` and `mem`, not on `rd_ready`.

## Test plan
- Reset, then push 0xA5 with `rd_ready` = 0 -> one cycle later `rd_valid` = 1, `rd_data` = 0xA5, `level` = 1. Assert `rd_ready` for 1 cycle -> `empty` = 1, `level` = 0.
- Push 0x00–0x0F (16 bytes) with `rd_ready` = 0 -> `full` = 1, `level` = 16. Push 0x10 and 0x11 -> `ovf` = 1, `ovf_cnt` = 2. Drain -> reads are 0x00…0x0F in order, and 0x10/0x11 are absent.
- FIFO full, push 0x55 in the same cycle as a pop -> write accepted, `level` stays 16, `ovf_cnt` unchanged. After draining, 0x55 is the last byte read.
- Continuous push of 40 random bytes with `rd_ready` = 1 for 40 cycles -> reads match the writes in order, `level` ≤ 1, pointers wrap past 15 with no loss.
- Hold `full` for 300 drops -> `ovf_cnt` saturates at 255. Assert `clr_ovf` together with a further drop -> `ovf_cnt` = 1, `ovf` = 1. Assert `clr_ovf` alone -> both 0.
- Fill 5 bytes, assert `arstn` low mid-cycle -> outputs go to reset values immediately. With `en` = 0, a `wr_valid` strobe -> `level` unchanged and `ovf_cnt` unchanged.
